gtp_frame_rcv: RTL and testbench
================================

Name: gtp_frame_rcv

Overview:
- Per-link deframer between a GTP receive lane (16-bit data + K-char flag, 125 MHz domain) and the receive FIFO write port.
- Detects start-of-frame, validates header length, strips idles and framing, forwards header + payload words with write strobes, and checks the trailing checksum.
- Keeps per-link frame and error counters for the Wishbone status registers.
- One instance per lane (A..D); output feeds the FIFO data/valid inputs directly.

Parameters:
- SOF_WORD, 16'hF7F7, K-word that opens a frame (kchar_i=1)
- IDLE_WORD, 16'h50BC, K-word used as idle/clock-correction filler; dropped everywhere
- MAX_LEN, 12'd1024, largest legal payload length in words

Ports:
- clk  in  1  125 MHz GTP user clock; only clock
- rst_n  in  1  asynchronous active-low reset
- en_i  in  1  link enable; sampled only in IDLE
- data_i  in  16  received GTP word
- kchar_i  in  1  1 = data_i is a K-word
- dat_o  out  16  word to FIFO
- vld_o  out  1  write strobe for dat_o
- sof_o  out  1  marks header word (with vld_o)
- eof_o  out  1  marks last payload word (with vld_o)
- done_o  out  1  one-cycle pulse: frame closed (good or bad)
- ok_o  out  1  valid with done_o: 1 = checksum good
- err_o  out  1  one-cycle pulse on any framing/checksum error
- err_code_o  out  2  last error cause: 1 bad length, 2 unexpected K-word, 3 checksum; holds until next error
- frm_cnt_o  out  16  good frames, wraps at FFFF->0000
- err_cnt_o  out  16  errors, saturates at FFFF

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0, both counters 0, err_code_o 0.
- All outputs registered; input word to dat_o/vld_o latency is exactly 1 cycle.
- Frame format: SOF_WORD (K) | header (non-K: [15:12] channel, [11:0] length N) | N payload words (non-K) | checksum (non-K).
- Checksum = 16-bit sum, mod 2^16, of header and all N payload words.
- An IDLE_WORD with kchar_i=1 is ignored in every state: no output, no state change, and no counter or sum change.
- IDLE:
  - kchar_i=1 and data_i=SOF_WORD and en_i=1 -> HEADER.
  - Anything else stays in IDLE silently.
- HEADER:
  - Non-K word with 1<=N<=MAX_LEN: emit it with vld_o=1, sof_o=1; sum<=word; remaining<=N; -> PAYLOAD.
  - Non-K word with N=0 or N>MAX_LEN: nothing emitted; err_o, err_code 1, done_o with ok_o=0; -> IDLE.
  - SOF_WORD: stay in HEADER, no error (repeated SOF).
  - Other K-word: error code 2; -> IDLE.
- PAYLOAD:
  - Non-K word: emit with vld_o=1; sum+=word; remaining-=1.
  - When remaining was 1, also assert eof_o and go -> CSUM.
  - SOF_WORD: error code 2, done_o with ok_o=0, nothing emitted; -> HEADER (new frame starts at once).
  - Other non-idle K-word: error code 2, done_o with ok_o=0; -> IDLE.
- CSUM:
  - Non-K word equal to sum: done_o=1, ok_o=1, frm_cnt++; -> IDLE.
  - Non-K word not equal to sum: done_o=1, ok_o=0, err_o, code 3; -> IDLE.
  - SOF_WORD: error code 2; -> HEADER.
  - Other K-word: error code 2; -> IDLE.
- Every err_o pulse increments err_cnt_o unless it is already FFFF; exactly one increment per error event.
- en_i deasserted mid-frame: the current frame finishes normally; no new SOF is accepted until en_i=1.
- rst_n asserted mid-frame: immediate return to IDLE with outputs 0; no done_o pulse for the aborted frame.
- sof_o/eof_o are never 1 without vld_o. When N=1, the single payload word carries eof_o. The header word never carries eof_o.

Test Plan:
- Good frame: SOF, hdr 16'h3002, 16'h1111, 16'h2222, csum 16'h6335 -> 3 vld_o words (hdr with sof_o, 2222 with eof_o), each 1 cycle after input; then done_o=1, ok_o=1, frm_cnt_o=1.
- Idle insertion: same frame with IDLE_WORD K between every word -> identical vld_o word sequence, frm_cnt_o=1, err_cnt_o=0.
- Bad checksum: same frame with csum 16'h6334 -> 3 words emitted, done_o=1, ok_o=0, err_o pulse, err_code_o=3, err_cnt_o=1.
- Bad length: SOF, hdr 16'h0000, then SOF, hdr 16'h0401 (N=1025 > MAX_LEN) -> no vld_o, two err_o pulses, err_code_o=1, err_cnt_o=2.
- Truncation: SOF, hdr 16'h0003, 1 payload word, SOF, then a good 1-word frame -> err_code_o=2, first frame has no eof_o, second frame ok_o=1, frm_cnt_o=1.
- Saturation and reset: force 65537 bad-length frames -> err_cnt_o stays FFFF. Then pulse rst_n low mid-PAYLOAD -> all outputs 0 asynchronously; next good frame gives frm_cnt_o=1.

Source files
------------

// File: rtl/gtp_frame_rcv.sv
`default_nettype none
// ============================================================================
//  Module   : gtp_frame_rcv
//  Purpose  : Per-lane deframer between a GTP receive lane (16-bit word plus
//             K-char flag, 125 MHz) and the receive FIFO write port. Finds
//             start-of-frame, validates the header length, drops idles and
//             framing, forwards header + payload words with write strobes,
//             checks the trailing 16-bit checksum and keeps per-lane frame
//             and error counters for the status registers.
//  Ports    : clk          - 125 MHz GTP user clock
//             rst_n        - asynchronous active-low reset
//             en_i         - link enable, only looked at while idle
//             data_i       - received GTP word
//             kchar_i      - data_i is a K-word
//             dat_o/vld_o  - FIFO write data / strobe (1 cycle latency)
//             sof_o/eof_o  - header word / last payload word markers
//             done_o/ok_o  - frame closed pulse / checksum good qualifier
//             err_o        - error pulse; err_code_o holds the last cause
//             frm_cnt_o    - good frames (wrapping)
//             err_cnt_o    - error events (saturating)
//  Revision : 1.0 - initial release
// ============================================================================
module gtp_frame_rcv #(
    parameter logic [15:0] SOF_WORD  = 16'hF7F7,
    parameter logic [15:0] IDLE_WORD = 16'h50BC,
    parameter logic [11:0] MAX_LEN   = 12'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [15:0] data_i,
    input  logic        kchar_i,
    output logic [15:0] dat_o,
    output logic        vld_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic        done_o,
    output logic        ok_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [15:0] frm_cnt_o,
    output logic [15:0] err_cnt_o
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_HEADER  = 2'd1;
    localparam logic [1:0] c_ST_PAYLOAD = 2'd2;
    localparam logic [1:0] c_ST_CSUM    = 2'd3;

    localparam logic [1:0] c_ERR_LEN  = 2'd1;
    localparam logic [1:0] c_ERR_K    = 2'd2;
    localparam logic [1:0] c_ERR_CSUM = 2'd3;

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [15:0] r_sum;
    logic [11:0] r_rem;
    logic [15:0] r_dat;
    logic        r_vld;
    logic        r_sof;
    logic        r_eof;
    logic        r_done;
    logic        r_ok;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic [15:0] r_frm_cnt;
    logic [15:0] r_err_cnt;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    logic [1:0]  w_state_nxt;
    logic [15:0] w_sum_nxt;
    logic [11:0] w_rem_nxt;
    logic        w_vld;
    logic        w_sof;
    logic        w_eof;
    logic        w_done;
    logic        w_ok;
    logic        w_err;
    logic [1:0]  w_err_code_nxt;
    logic [15:0] w_frm_cnt_nxt;
    logic [15:0] w_err_cnt_nxt;

    logic        w_is_idle;
    logic        w_is_sof;
    logic [11:0] w_len;
    logic        w_len_ok;

    assign w_is_idle = kchar_i && (data_i == IDLE_WORD);
    assign w_is_sof  = kchar_i && (data_i == SOF_WORD);
    assign w_len     = data_i[11:0];
    assign w_len_ok  = (w_len != 12'd0) && (w_len <= MAX_LEN);

    always_comb begin
        w_state_nxt    = r_state;
        w_sum_nxt      = r_sum;
        w_rem_nxt      = r_rem;
        w_vld          = 1'b0;
        w_sof          = 1'b0;
        w_eof          = 1'b0;
        w_done         = 1'b0;
        w_ok           = 1'b0;
        w_err          = 1'b0;
        w_err_code_nxt = r_err_code;

        // Idle/clock-correction words are invisible in every state.
        if (!w_is_idle) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_is_sof && en_i) begin
                        w_state_nxt = c_ST_HEADER;
                    end
                end

                c_ST_HEADER: begin
                    if (!kchar_i) begin
                        if (w_len_ok) begin
                            w_vld       = 1'b1;
                            w_sof       = 1'b1;
                            w_sum_nxt   = data_i;
                            w_rem_nxt   = w_len;
                            w_state_nxt = c_ST_PAYLOAD;
                        end else begin
                            w_err          = 1'b1;
                            w_done         = 1'b1;
                            w_err_code_nxt = c_ERR_LEN;
                            w_state_nxt    = c_ST_IDLE;
                        end
                    end else if (!w_is_sof) begin
                        // A repeated SOF simply re-arms; any other K-word aborts.
                        w_err          = 1'b1;
                        w_done         = 1'b1;
                        w_err_code_nxt = c_ERR_K;
                        w_state_nxt    = c_ST_IDLE;
                    end
                end

                c_ST_PAYLOAD: begin
                    if (!kchar_i) begin
                        w_vld     = 1'b1;
                        w_sum_nxt = r_sum + data_i;
                        w_rem_nxt = r_rem - 12'd1;
                        if (r_rem == 12'd1) begin
                            w_eof       = 1'b1;
                            w_state_nxt = c_ST_CSUM;
                        end
                    end else begin
                        // Truncated frame; an SOF opens the next frame at once.
                        w_err          = 1'b1;
                        w_done         = 1'b1;
                        w_err_code_nxt = c_ERR_K;
                        w_state_nxt    = w_is_sof ? c_ST_HEADER : c_ST_IDLE;
                    end
                end

                c_ST_CSUM: begin
                    if (!kchar_i) begin
                        w_done = 1'b1;
                        if (data_i == r_sum) begin
                            w_ok = 1'b1;
                        end else begin
                            w_err          = 1'b1;
                            w_err_code_nxt = c_ERR_CSUM;
                        end
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_err          = 1'b1;
                        w_done         = 1'b1;
                        w_err_code_nxt = c_ERR_K;
                        w_state_nxt    = w_is_sof ? c_ST_HEADER : c_ST_IDLE;
                    end
                end

                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // Counters are recomputed every cycle so each register is rewritten
    // from its own current value on every clock.
    always_comb begin
        w_frm_cnt_nxt = r_frm_cnt;
        if (w_ok) begin
            w_frm_cnt_nxt = r_frm_cnt + 16'd1;
        end
        w_err_cnt_nxt = r_err_cnt;
        if (w_err && (r_err_cnt != 16'hFFFF)) begin
            w_err_cnt_nxt = r_err_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_sum      <= 16'd0;
            r_rem      <= 12'd0;
            r_dat      <= 16'd0;
            r_vld      <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_done     <= 1'b0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_frm_cnt  <= 16'd0;
            r_err_cnt  <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_sum      <= w_sum_nxt;
            r_rem      <= w_rem_nxt;
            if (w_vld) begin
                r_dat <= data_i;
            end
            r_vld      <= w_vld;
            r_sof      <= w_sof;
            r_eof      <= w_eof;
            r_done     <= w_done;
            r_ok       <= w_ok;
            r_err      <= w_err;
            r_err_code <= w_err_code_nxt;
            r_frm_cnt  <= w_frm_cnt_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    assign dat_o      = r_dat;
    assign vld_o      = r_vld;
    assign sof_o      = r_sof;
    assign eof_o      = r_eof;
    assign done_o     = r_done;
    assign ok_o       = r_ok;
    assign err_o      = r_err;
    assign err_code_o = r_err_code;
    assign frm_cnt_o  = r_frm_cnt;
    assign err_cnt_o  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gtp_frame_rcv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gtp_frame_rcv
//  Purpose  : Self-checking bench for gtp_frame_rcv. Directed steps push the
//             expected FIFO words and frame-close events into scoreboards;
//             negedge monitors pop and compare them as the DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gtp_frame_rcv;

    localparam logic [15:0] c_SOF  = 16'hF7F7;
    localparam logic [15:0] c_IDLE = 16'h50BC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic [15:0] data_i;
    logic        kchar_i;
    logic [15:0] dat_o;
    logic        vld_o;
    logic        sof_o;
    logic        eof_o;
    logic        done_o;
    logic        ok_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic [15:0] frm_cnt_o;
    logic [15:0] err_cnt_o;

    gtp_frame_rcv dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .data_i     (data_i),
        .kchar_i    (kchar_i),
        .dat_o      (dat_o),
        .vld_o      (vld_o),
        .sof_o      (sof_o),
        .eof_o      (eof_o),
        .done_o     (done_o),
        .ok_o       (ok_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .frm_cnt_o  (frm_cnt_o),
        .err_cnt_o  (err_cnt_o)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] dat;
        logic        sof;
        logic        eof;
        int          cyc;
    } word_t;

    typedef struct {
        logic ok;
        logic err;
        int   cyc;
    } close_t;

    word_t  wq[$];
    close_t dq[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output word scoreboard: value, markers and exact 1-cycle latency.
    always @(negedge clk) begin
        if (vld_o || sof_o || eof_o) begin
            chk("word_expected", 64'(wq.size() != 0), 64'(1));
            if (wq.size() != 0) begin
                word_t e;
                e = wq.pop_front();
                chk("word", {14'd0, vld_o, dat_o, sof_o, eof_o, cyc},
                            {14'd0, 1'b1, e.dat, e.sof, e.eof, e.cyc});
            end
        end
        if (done_o || ok_o || err_o) begin
            chk("close_expected", 64'(dq.size() != 0), 64'(1));
            if (dq.size() != 0) begin
                close_t c;
                c = dq.pop_front();
                chk("close", {29'd0, done_o, ok_o, err_o, cyc},
                             {29'd0, 1'b1, c.ok, c.err, c.cyc});
            end
        end
    end

    // Drive one lane word; optionally expect an output word and/or a frame close.
    task automatic put(input logic k, input logic [15:0] d,
                       input logic ev, input logic es, input logic ee,
                       input logic ed, input logic eok);
        @(negedge clk);
        kchar_i = k;
        data_i  = d;
        if (ev) wq.push_back('{dat: d, sof: es, eof: ee, cyc: cyc + 1});
        if (ed) dq.push_back('{ok: eok, err: !eok, cyc: cyc + 1});
    endtask

    task automatic sofw();
        put(1'b1, c_SOF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idl();
        put(1'b1, c_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic badlen(input logic [15:0] hdr);
        sofw();
        put(1'b0, hdr, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Full frame: payload word i = base + i*step; checksum XORed with csum_x.
    task automatic frame(input logic [15:0] hdr, input logic [15:0] base,
                         input logic [15:0] step, input bit idles,
                         input logic [15:0] csum_x);
        logic [15:0] sum;
        logic [15:0] w;
        int n;
        n   = int'(hdr[11:0]);
        sum = hdr;
        sofw();
        if (idles) idl();
        put(1'b0, hdr, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        if (idles) idl();
        for (int i = 0; i < n; i++) begin
            w   = base + 16'(i) * step;
            sum = sum + w;
            put(1'b0, w, 1'b1, 1'b0, (i == n - 1), 1'b0, 1'b0);
            if (idles) idl();
        end
        put(1'b0, sum ^ csum_x, 1'b0, 1'b0, 1'b0, 1'b1, (csum_x == 16'd0));
    endtask

    task automatic cnts(input string tag, input logic [15:0] frm,
                        input logic [15:0] errs, input logic [1:0] code);
        chk(tag, {30'd0, frm_cnt_o, err_cnt_o, err_code_o}, {30'd0, frm, errs, code});
    endtask

    initial begin
        rst_n   = 1'b0;
        en_i    = 1'b1;
        kchar_i = 1'b1;
        data_i  = c_IDLE;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {5'd0, dat_o, vld_o, sof_o, eof_o, done_o, ok_o, err_o,
                              err_code_o, frm_cnt_o, err_cnt_o}, 64'd0);
        rst_n = 1'b1;
        idl();

        // Basic good frame: hdr 3002, 1111, 2222, csum 6335.
        frame(16'h3002, 16'h1111, 16'h1111, 1'b0, 16'h0000);
        idl();
        cnts("good_frame_cnt", 16'd1, 16'd0, 2'd0);

        // Same frame with idles between every word.
        frame(16'h3002, 16'h1111, 16'h1111, 1'b1, 16'h0000);
        idl();
        cnts("idle_frame_cnt", 16'd2, 16'd0, 2'd0);

        // Bad checksum 6334.
        frame(16'h3002, 16'h1111, 16'h1111, 1'b0, 16'h0001);
        idl();
        cnts("bad_csum_cnt", 16'd2, 16'd1, 2'd3);

        // Zero length and N = MAX_LEN + 1.
        badlen(16'h0000);
        badlen(16'h0401);
        idl();
        cnts("bad_len_cnt", 16'd2, 16'd3, 2'd1);

        // Truncation by SOF, then a good 1-word frame in the reopened header.
        sofw();
        put(1'b0, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        put(1'b0, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        put(1'b1, c_SOF,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        put(1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        put(1'b0, 16'hABCD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        put(1'b0, 16'hABCE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idl();
        cnts("trunc_cnt", 16'd3, 16'd4, 2'd2);

        // Link disabled: SOF ignored, following words silent.
        en_i = 1'b0;
        sofw();
        put(1'b0, 16'h3002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        put(1'b0, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idl();
        cnts("disabled_cnt", 16'd3, 16'd4, 2'd2);

        // Enable dropped mid-frame: frame still completes.
        en_i = 1'b1;
        sofw();
        put(1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        en_i = 1'b0;
        put(1'b0, 16'h0F0F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        put(1'b0, 16'h0F10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        sofw();
        put(1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idl();
        cnts("en_drop_cnt", 16'd4, 16'd4, 2'd2);
        en_i = 1'b1;

        // Largest legal frame, N = 1024.
        frame(16'h0400, 16'h0000, 16'h0001, 1'b0, 16'h0000);
        idl();
        cnts("max_len_cnt", 16'd5, 16'd4, 2'd2);

        // Stray K-word inside payload.
        sofw();
        put(1'b0, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        put(1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        put(1'b1, 16'h1C1C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idl();
        cnts("k_payload_cnt", 16'd5, 16'd5, 2'd2);

        // Saturation: preload the error counter near the top, then overflow it.
        @(negedge clk);
        force dut.r_err_cnt = 16'hFFFD;
        repeat (2) @(negedge clk);
        release dut.r_err_cnt;
        badlen(16'h0000);
        badlen(16'h0000);
        idl();
        cnts("sat_reach_cnt", 16'd5, 16'hFFFF, 2'd1);
        badlen(16'h0000);
        idl();
        cnts("sat_hold_cnt", 16'd5, 16'hFFFF, 2'd1);

        // Asynchronous reset in the middle of a payload.
        sofw();
        put(1'b0, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        put(1'b0, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_reset_vld", {47'd0, vld_o, dat_o}, {47'd0, 1'b1, 16'h7777});
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {5'd0, dat_o, vld_o, sof_o, eof_o, done_o, ok_o, err_o,
                            err_code_o, frm_cnt_o, err_cnt_o}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idl();
        frame(16'h3002, 16'h1111, 16'h1111, 1'b0, 16'h0000);
        idl();
        cnts("post_reset_cnt", 16'd1, 16'd0, 2'd0);

        repeat (3) idl();
        chk("words_drained", 64'(wq.size()), 64'd0);
        chk("closes_drained", 64'(dq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
